cmos_pixel_packer: RTL and testbench
====================================

CMOS_PIXEL_PACKER -- requirements
Module: cmos_pixel_packer

Interface
REQ-001 SHALL have parameter IN_W, default 8: width of one camera beat.
REQ-002 SHALL have parameter RATIO, default 2, legal range 1..4: beats per output pixel. OUT_W = IN_W*RATIO (derived, not overridable).
REQ-003 SHALL have parameter SKIP_FRAMES, default 0, legal range 0..15: whole frames discarded after reset.
REQ-004 SHALL have port pclk, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port vsync_i, input, 1: frame sync, active-high.
REQ-007 SHALL have port de_i, input, 1: beat valid / line active.
REQ-008 SHALL have port pdata_i, input, IN_W: camera beat.
REQ-009 SHALL have port swap_i, input, 1: beat order select, 0 = first beat in MSBs.
REQ-010 SHALL have port pdata_o, output, OUT_W: assembled pixel.
REQ-011 SHALL have port de_o, output, 1: one-cycle strobe, pdata_o valid.
REQ-012 SHALL have port sof_o, output, 1: coincident with de_o of first pixel of a frame.
REQ-013 SHALL have port eol_o, output, 1: one-cycle pulse, line ended.
REQ-014 SHALL have port line_act_o, output, 1: de_i delayed one cycle.
REQ-015 SHALL have port err_o, output, 1: sticky, partial pixel seen at line end.
REQ-016 SHALL have ports line_cnt_o and pix_cnt_o, output, 12 each: statistics.

Function
REQ-017 SHALL use FSM states WAIT_FRAME, SKIP, ACTIVE. WAIT_FRAME -> SKIP on vsync_i falling edge when skip counter < SKIP_FRAMES, else -> ACTIVE. SKIP -> WAIT_FRAME on next vsync_i rising edge, incrementing skip counter (saturates at SKIP_FRAMES). ACTIVE -> WAIT_FRAME on vsync_i rising edge.
REQ-018 SHALL ignore de_i outside ACTIVE and whenever vsync_i is high.
REQ-019 SHALL clear beat counter to 0 on every de_i rising edge and whenever de_i is low.
REQ-020 SHALL, per accepted beat, store pdata_i in slot = beat index, counting 0..RATIO-1, then wrap to 0.
REQ-021 SHALL, on the cycle after the beat with index RATIO-1, assert de_o for one cycle and present the pixel on pdata_o (latency 1 cycle from last beat).
REQ-022 Beat order: swap_i=0 places beat 0 in the MSBs; swap_i=1 places beat 0 in the LSBs. swap_i SHALL be sampled only on the WAIT_FRAME->ACTIVE transition.
REQ-023 SHALL hold pdata_o between strobes.
REQ-024 SHALL assert sof_o with the first de_o after entering ACTIVE only.
REQ-025 SHALL pulse eol_o the cycle after de_i falls in ACTIVE.
REQ-026 If de_i falls with beat counter != 0, SHALL discard the partial pixel (no de_o) and set err_o. err_o SHALL clear only on rst.
REQ-027 RATIO=1: every accepted beat SHALL produce de_o the next cycle; err_o never sets.
REQ-028 A de_i gap of one cycle SHALL count as a line end: eol_o pulses and the counter restarts.

Reset
REQ-029 On rst, SHALL force: state WAIT_FRAME, skip counter 0, beat counter 0, pdata_o 0, de_o/sof_o/eol_o/line_act_o/err_o 0, line_cnt_o/pix_cnt_o 0.
REQ-030 rst mid-line/mid-frame SHALL discard all partial data; output SHALL resume only after the next vsync_i falling edge.

Configuration
REQ-031 Macro CMOS_PACK_STATS_EN defined: line_cnt_o counts eol_o pulses in the current frame (cleared on entry to ACTIVE); pix_cnt_o holds the de_o count of the last completed line (updated with eol_o); both saturate at 4095.
REQ-032 Macro CMOS_PACK_STATS_EN undefined: counters SHALL not be built and line_cnt_o/pix_cnt_o SHALL be tied to 0.

Verification
REQ-033 IN_W=8, RATIO=2, swap_i=0; vsync pulse, then de beats 0xAB,0xCD -> de_o one cycle after 0xCD, pdata_o=0xABCD, sof_o=1.
REQ-034 Same stimulus with swap_i=1 latched at frame start -> pdata_o=0xCDAB; toggling swap_i mid-frame has no effect.
REQ-035 Line of 5 beats, RATIO=2 -> two de_o strobes, eol_o pulse, err_o=1 and stays 1 until rst.
REQ-036 SKIP_FRAMES=2, four frames -> no de_o during frames 1-2; sof_o on first pixel of frame 3.
REQ-037 STATS_EN defined, frame of 3 lines x 640 pixels -> pix_cnt_o=640, line_cnt_o=3 before next vsync; undefined -> both 0.
REQ-038 rst asserted mid-line -> all outputs 0 next cycle; no de_o until after the next vsync_i fall.

Source files
------------

// File: rtl/cmos_pixel_packer.sv
// Packs RATIO narrow camera beats into one wide pixel, with frame skip and line error flag.
// Optional per-frame line/pixel statistics are built when CMOS_PACK_STATS_EN is defined.
//
// state        | meaning
// WAIT_FRAME   | idle until vsync_i falls, then skip or go active
// SKIP         | discarding a whole frame, leaves on next vsync_i rise
// ACTIVE       | accepting beats and emitting pixels until vsync_i rises
module cmos_pixel_packer #(
  parameter int IN_W        = 8,
  parameter int RATIO       = 2,
  parameter int SKIP_FRAMES = 0
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    vsync_i,
  input  logic                    de_i,
  input  logic [IN_W-1:0]         pdata_i,
  input  logic                    swap_i,
  output logic [IN_W*RATIO-1:0]   pdata_o,
  output logic                    de_o,
  output logic                    sof_o,
  output logic                    eol_o,
  output logic                    line_act_o,
  output logic                    err_o,
  output logic [11:0]             line_cnt_o,
  output logic [11:0]             pix_cnt_o
);

  localparam int OUT_W = IN_W * RATIO;

  localparam logic [1:0] S_WAIT_FRAME = 2'd0;
  localparam logic [1:0] S_SKIP       = 2'd1;
  localparam logic [1:0] S_ACTIVE     = 2'd2;

  logic [1:0]      r_state;
  logic            r_vsync_d;
  logic            r_de_d;
  logic            r_swap;
  logic            r_first;
  logic [3:0]      r_skip_cnt;
  logic [1:0]      r_beat_cnt;
  logic [IN_W-1:0] r_slot [RATIO];

  logic            w_vs_rise;
  logic            w_vs_fall;
  logic            w_de_acc;
  logic            w_last_beat;
  logic            w_line_end;
  logic            w_enter_active;
  logic [IN_W-1:0] w_beats [RATIO];
  logic [OUT_W-1:0] w_pixel;

  assign w_vs_rise      = vsync_i & ~r_vsync_d;
  assign w_vs_fall      = ~vsync_i & r_vsync_d;
  assign w_de_acc       = de_i & ~vsync_i & (r_state == S_ACTIVE);
  assign w_last_beat    = w_de_acc & (r_beat_cnt == 2'(RATIO - 1));
  assign w_line_end     = r_de_d & ~w_de_acc & (r_state == S_ACTIVE);
  assign w_enter_active = (r_state == S_WAIT_FRAME) & w_vs_fall &
                          (r_skip_cnt == 4'(SKIP_FRAMES));

  // Current beat bypasses its slot so the pixel is ready on the last beat's edge.
  always_comb begin
    w_pixel = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_beats[k] = (2'(k) == r_beat_cnt) ? pdata_i : r_slot[k];
      if (r_swap)
        w_pixel[k*IN_W +: IN_W] = w_beats[k];
      else
        w_pixel[(RATIO-1-k)*IN_W +: IN_W] = w_beats[k];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int k = 0; k < RATIO; k++) r_slot[k] <= '0;
    end else begin
      for (int k = 0; k < RATIO; k++)
        if (w_de_acc && (2'(k) == r_beat_cnt)) r_slot[k] <= pdata_i;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state    <= S_WAIT_FRAME;
      r_vsync_d  <= 1'b0;
      r_de_d     <= 1'b0;
      r_swap     <= 1'b0;
      r_first    <= 1'b0;
      r_skip_cnt <= 4'd0;
      r_beat_cnt <= 2'd0;
      pdata_o    <= '0;
      de_o       <= 1'b0;
      sof_o      <= 1'b0;
      eol_o      <= 1'b0;
      line_act_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      r_vsync_d  <= vsync_i;
      r_de_d     <= w_de_acc;
      line_act_o <= de_i;
      de_o       <= w_last_beat;
      sof_o      <= w_last_beat & r_first;
      eol_o      <= w_line_end;

      if (w_last_beat) begin
        pdata_o <= w_pixel;
        r_first <= 1'b0;
      end

      // A line that ends mid-pixel drops the partial beats and latches the error.
      if (w_line_end && (r_beat_cnt != 2'd0)) err_o <= 1'b1;

      if (w_de_acc)
        r_beat_cnt <= w_last_beat ? 2'd0 : r_beat_cnt + 2'd1;
      else
        r_beat_cnt <= 2'd0;

      case (r_state)
        S_WAIT_FRAME: begin
          if (w_vs_fall) begin
            if (w_enter_active) begin
              r_state <= S_ACTIVE;
              r_swap  <= swap_i;
              r_first <= 1'b1;
            end else begin
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (w_vs_rise) begin
            r_state <= S_WAIT_FRAME;
            if (r_skip_cnt != 4'(SKIP_FRAMES)) r_skip_cnt <= r_skip_cnt + 4'd1;
          end
        end
        S_ACTIVE: begin
          if (w_vs_rise) r_state <= S_WAIT_FRAME;
        end
        default: r_state <= S_WAIT_FRAME;
      endcase
    end
  end

`ifdef CMOS_PACK_STATS_EN
  logic [11:0] r_line_cnt;
  logic [11:0] r_pix_line;
  logic [11:0] r_pix_last;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_line_cnt <= 12'd0;
      r_pix_line <= 12'd0;
      r_pix_last <= 12'd0;
    end else if (w_enter_active) begin
      r_line_cnt <= 12'd0;
      r_pix_line <= 12'd0;
    end else if (w_line_end) begin
      if (r_line_cnt != 12'hFFF) r_line_cnt <= r_line_cnt + 12'd1;
      r_pix_last <= r_pix_line;
      r_pix_line <= 12'd0;
    end else if (w_last_beat && (r_pix_line != 12'hFFF)) begin
      r_pix_line <= r_pix_line + 12'd1;
    end
  end

  assign line_cnt_o = r_line_cnt;
  assign pix_cnt_o  = r_pix_last;
`else
  assign line_cnt_o = 12'd0;
  assign pix_cnt_o  = 12'd0;
`endif

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench for cmos_pixel_packer: default, frame-skip and RATIO=1 instances share stimulus.
module tb_cmos_pixel_packer;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_i;
  logic       de_i;
  logic [7:0] pdata_i;
  logic       swap_i;

  logic [15:0] pdata_o, pdata_s;
  logic [7:0]  pdata_1;
  logic        de_o, sof_o, eol_o, la_o, err_o;
  logic        de_s, sof_s, eol_s, la_s, err_s;
  logic        de_1, sof_1, eol_1, la_1, err_1;
  logic [11:0] lc_o, pc_o, lc_s, pc_s, lc_1, pc_1;

  int checks = 0;
  int errors = 0;
  int n_de = 0, n_sof = 0, n_eol = 0;
  int n_de_s = 0, n_sof_s = 0;
  int n_de1 = 0;
  logic [15:0] last_pix = '0, last_pix_s = '0;
  logic [7:0]  last_pix1 = '0;
  int de_snap;

  cmos_pixel_packer #(.IN_W(8), .RATIO(2), .SKIP_FRAMES(0)) u_dut (
    .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .swap_i(swap_i), .pdata_o(pdata_o), .de_o(de_o), .sof_o(sof_o), .eol_o(eol_o),
    .line_act_o(la_o), .err_o(err_o), .line_cnt_o(lc_o), .pix_cnt_o(pc_o));

  cmos_pixel_packer #(.IN_W(8), .RATIO(2), .SKIP_FRAMES(2)) u_dut_skip (
    .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .swap_i(swap_i), .pdata_o(pdata_s), .de_o(de_s), .sof_o(sof_s), .eol_o(eol_s),
    .line_act_o(la_s), .err_o(err_s), .line_cnt_o(lc_s), .pix_cnt_o(pc_s));

  cmos_pixel_packer #(.IN_W(8), .RATIO(1), .SKIP_FRAMES(0)) u_dut_r1 (
    .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .swap_i(swap_i), .pdata_o(pdata_1), .de_o(de_1), .sof_o(sof_1), .eol_o(eol_1),
    .line_act_o(la_1), .err_o(err_1), .line_cnt_o(lc_1), .pix_cnt_o(pc_1));

  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge and strobes tallied.
  task automatic tick();
    @(posedge pclk);
    #1;
    if (de_o) begin
      n_de++;
      last_pix = pdata_o;
      if (sof_o) n_sof++;
    end
    if (eol_o) n_eol++;
    if (de_s) begin
      n_de_s++;
      last_pix_s = pdata_s;
      if (sof_s) n_sof_s++;
    end
    if (de_1) begin
      n_de1++;
      last_pix1 = pdata_1;
    end
  endtask

  task automatic vs_pulse();
    vsync_i = 1'b1;
    repeat (3) tick();
    vsync_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic line(input int n, input logic [7:0] base);
    de_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      pdata_i = 8'(base + i);
      tick();
    end
    de_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic beats2(input logic [7:0] a, input logic [7:0] b);
    de_i = 1'b1;
    pdata_i = a;
    tick();
    pdata_i = b;
    tick();
    de_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; vsync_i = 1'b0; de_i = 1'b0; pdata_i = 8'h00; swap_i = 1'b0;
    repeat (3) tick();
    check_val("rst_flags", {27'd0, de_o, sof_o, eol_o, la_o, err_o}, 32'd0);
    check_val("rst_pdata", {16'd0, pdata_o}, 32'd0);
    check_val("rst_stats", {8'd0, lc_o, pc_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: swap=0, basic two-beat pixel with exact timing checks
    swap_i = 1'b0;
    vs_pulse();
    de_i = 1'b1; pdata_i = 8'hAB;
    tick();
    check_val("line_act", {31'd0, la_o}, 32'd1);
    check_val("no_de_first_beat", {31'd0, de_o}, 32'd0);
    pdata_i = 8'hCD;
    tick();
    check_val("de_after_last", {31'd0, de_o}, 32'd1);
    check_val("pix_abcd", {16'd0, pdata_o}, 32'h0000ABCD);
    check_val("sof_first", {31'd0, sof_o}, 32'd1);
    de_i = 1'b0;
    tick();
    check_val("eol_pulse", {30'd0, eol_o, de_o}, 32'd2);
    check_val("pdata_hold", {16'd0, pdata_o}, 32'h0000ABCD);
    repeat (2) tick();
    check_val("err_clean", {31'd0, err_o}, 32'd0);
    check_val("r1_count", n_de1, 32'd2);
    check_val("r1_last", {24'd0, last_pix1}, 32'h000000CD);

    line(2, 8'h12);
    check_val("pix_1213", {16'd0, last_pix}, 32'h00001213);
    check_val("sof_once", n_sof, 32'd1);

    // Frame 2: swap latched at frame start, toggled away mid-frame
    swap_i = 1'b1;
    vs_pulse();
    swap_i = 1'b0;
    beats2(8'hAB, 8'hCD);
    check_val("pix_cdab", {16'd0, last_pix}, 32'h0000CDAB);
    check_val("sof_frame2", n_sof, 32'd2);

    line(5, 8'h01);
    check_val("odd_line_de", n_de, 32'd5);
    check_val("odd_line_pix", {16'd0, last_pix}, 32'h00000403);
    check_val("err_set", {31'd0, err_o}, 32'd1);
    check_val("eol_count", n_eol, 32'd4);
    check_val("r1_odd_count", n_de1, 32'd11);
    check_val("r1_no_err", {31'd0, err_1}, 32'd0);
    check_val("skip_f12", n_de_s, 32'd0);

    // Frame 3: skip instance becomes active
    swap_i = 1'b0;
    vs_pulse();
    beats2(8'hAB, 8'hCD);
    check_val("skip_f3_de", n_de_s, 32'd1);
    check_val("skip_f3_sof", n_sof_s, 32'd1);
    check_val("skip_f3_pix", {16'd0, last_pix_s}, 32'h0000ABCD);
    check_val("err_sticky", {31'd0, err_o}, 32'd1);

    // Frame 4: three lines of 640 pixels
    vs_pulse();
    de_snap = n_de;
    repeat (3) line(1280, 8'h00);
`ifdef CMOS_PACK_STATS_EN
    check_val("pix_cnt", {20'd0, pc_o}, 32'd640);
    check_val("line_cnt", {20'd0, lc_o}, 32'd3);
`else
    check_val("pix_cnt", {20'd0, pc_o}, 32'd0);
    check_val("line_cnt", {20'd0, lc_o}, 32'd0);
`endif
    check_val("f4_de", n_de - de_snap, 32'd1920);
    check_val("skip_f4_sof", n_sof_s, 32'd2);
    check_val("err_sticky2", {31'd0, err_o}, 32'd1);

    // Reset mid-line
    de_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pdata_i = 8'(8'h50 + i);
      tick();
    end
    rst = 1'b1;
    tick();
    check_val("midrst_flags", {27'd0, de_o, sof_o, eol_o, la_o, err_o}, 32'd0);
    check_val("midrst_pdata", {16'd0, pdata_o}, 32'd0);
    check_val("midrst_stats", {8'd0, lc_o, pc_o}, 32'd0);
    rst = 1'b0;
    de_snap = n_de;
    repeat (4) begin
      pdata_i = 8'h77;
      tick();
    end
    de_i = 1'b0;
    repeat (2) tick();
    check_val("no_de_after_rst", n_de - de_snap, 32'd0);
    vs_pulse();
    beats2(8'h11, 8'h22);
    check_val("resume_de", n_de - de_snap, 32'd1);
    check_val("resume_pix", {16'd0, last_pix}, 32'h00001122);
    check_val("err_cleared", {31'd0, err_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
